// File: rtl/sw_led_sequencer.sv
// Switch debouncer / datapath issuer / LED register for the 8-switch, 2-LED lab datapath.
// Optional pending-blink on the LEDs is enabled by defining SWSEQ_BLINK_EN.
module sw_led_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8,
   parameter int BLINK_DIV       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sw,
   output logic [7:0] dp_sw,
   output logic       dp_valid,
   input  logic       dp_ready,
   input  logic [1:0] dp_led,
   output logic       Led1,
   output logic       Led2,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_param
      $error("sw_led_sequencer: all cycle parameters must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, DEBOUNCE, ISSUE, HOLD} state_t;

   state_t        state;
   logic [7:0]    committed;
   logic [7:0]    cand;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic          led1_r;
   logic          led2_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dp_sw     <= '0;
         dp_valid  <= 1'b0;
         led1_r    <= 1'b0;
         led2_r    <= 1'b0;
         busy      <= 1'b0;
         committed <= '0;
         cand      <= '0;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sw != committed) begin
                  cand    <= sw;
                  deb_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (sw != cand) begin
                  cand    <= sw;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
                  if (deb_cnt == DEB_LAST) begin
                     if (cand == committed) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        dp_sw <= cand;
                        state <= ISSUE;
                     end
                  end
               end
            end
            ISSUE: begin
               // First ISSUE cycle only raises dp_valid, giving DEBOUNCE_CYCLES+1 latency.
               if (!dp_valid) begin
                  dp_valid <= 1'b1;
               end else if (dp_ready) begin
                  dp_valid  <= 1'b0;
                  led1_r    <= dp_led[0];
                  led2_r    <= dp_led[1];
                  committed <= dp_sw;
                  hold_cnt  <= '0;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt + 1'b1;
               if (hold_cnt == HOLD_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SWSEQ_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV) + 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] blink_cnt;
   logic          toggle;
   logic          pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         toggle    <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         toggle    <= ~toggle;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      pending = (state == DEBOUNCE) || (state == ISSUE);
      Led1    = led1_r & (toggle | ~pending);
      Led2    = led2_r & (toggle | ~pending);
   end
`else
   always_comb begin
      Led1 = led1_r;
      Led2 = led2_r;
   end
`endif

endmodule

// File: tb/tb_sw_led_sequencer.sv
// Scoreboard bench for sw_led_sequencer: stimulus pushes expected handshakes,
// a monitor pops and compares at each dp_valid & dp_ready.
module tb_sw_led_sequencer;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] dp_sw;
   logic       dp_valid;
   logic       dp_ready;
   logic [1:0] dp_led;
   logic       Led1;
   logic       Led2;
   logic       busy;

   typedef struct packed {
      logic [7:0] sw;
      logic [1:0] led;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   hs_count = 0;

   always #5 clk = ~clk;

   sw_led_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES(HOLD),
      .BLINK_DIV(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw(sw),
      .dp_sw(dp_sw),
      .dp_valid(dp_valid),
      .dp_ready(dp_ready),
      .dp_led(dp_led),
      .Led1(Led1),
      .Led2(Led2),
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int lim, output int n);
      n = 0;
      while (dp_valid !== 1'b1 && n < lim) begin
         tick();
         n++;
      end
      chk(name, {31'd0, dp_valid}, 32'd1);
   endtask

   task automatic wait_idle(input string name, input int lim, output int n);
      n = 0;
      while (busy !== 1'b0 && n < lim) begin
         tick();
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   // Monitor: every handshake must match the oldest pushed expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && dp_valid === 1'b1 && dp_ready === 1'b1) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_handshake: got dp_sw %0h expected none at %0t", dp_sw, $time);
            end else begin
               e = exp_q.pop_front();
               chk("hs_dp_sw", {24'd0, dp_sw}, {24'd0, e.sw});
               @(negedge clk);
               chk("hs_led1", {31'd0, Led1}, {31'd0, e.led[0]});
               chk("hs_led2", {31'd0, Led2}, {31'd0, e.led[1]});
               chk("hs_valid_drop", {31'd0, dp_valid}, 32'd0);
            end
         end
      end
   end

   initial begin
      #100000;
      checks++;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int  n;
      bit  seen0, seen1, seen_valid;

      // 1: reset and quiet idle
      rst = 1'b1; sw = 8'h00; dp_ready = 1'b1; dp_led = 2'b00;
      tick(); tick();
      chk("rst_dp_valid", {31'd0, dp_valid}, 32'd0);
      chk("rst_dp_sw", {24'd0, dp_sw}, 32'd0);
      chk("rst_leds", {30'd0, Led2, Led1}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_quiet", {28'd0, dp_valid, busy, Led2, Led1}, 32'd0);
      end

      // 3: glitch 00->01 for 2 cycles ->00 must not issue
      sw = 8'h01;
      tick();
      chk("glitch_busy", {31'd0, busy}, 32'd1);
      tick();
      sw = 8'h00;
      n = 0; seen_valid = 0;
      while (busy !== 1'b0 && n < 12) begin
         tick();
         n++;
         if (dp_valid === 1'b1) seen_valid = 1;
      end
      chk("glitch_return_cycles", n, DEB + 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dp_valid === 1'b1) seen_valid = 1;
      end
      chk("glitch_no_valid", {31'd0, seen_valid}, 32'd0);
      chk("glitch_idle", {31'd0, busy}, 32'd0);

      // 2: 0x55 -> Led1=0, Led2=1
      sw = 8'h55; dp_led = 2'b10;
      exp_q.push_back('{sw: 8'h55, led: 2'b10});
      wait_valid("t2_valid", 20, n);
      chk("t2_latency", n, DEB + 2);
      chk("t2_dp_sw", {24'd0, dp_sw}, 32'h55);
      tick();
      chk("t2_valid_1cycle", {31'd0, dp_valid}, 32'd0);
      chk("t2_leds", {30'd0, Led2, Led1}, 32'd2);
      wait_idle("t2_idle", 20, n);
      chk("t2_hold_cycles", n, HOLD);

      // 4: 0x0E stalled by dp_ready=0 while sw moves to 0x76
      sw = 8'h0E; dp_led = 2'b01; dp_ready = 1'b0;
      exp_q.push_back('{sw: 8'h0E, led: 2'b01});
      wait_valid("t4_valid", 20, n);
      sw = 8'h76;
      seen0 = 0; seen1 = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_stall_valid", {31'd0, dp_valid}, 32'd1);
         chk("t4_stall_dp_sw", {24'd0, dp_sw}, 32'h0E);
         if (Led2 === 1'b0) seen0 = 1;
         if (Led2 === 1'b1) seen1 = 1;
      end
`ifdef SWSEQ_BLINK_EN
      chk("t4_blink", {30'd0, seen1, seen0}, 32'd3);
`else
      chk("t4_led_steady", {30'd0, seen1, seen0}, 32'd2);
`endif
      exp_q.push_back('{sw: 8'h76, led: 2'b11});
      dp_ready = 1'b1;
      tick();
      chk("t4_leds", {30'd0, Led2, Led1}, 32'd1);
      dp_led = 2'b11;
      wait_valid("t4_reissue_valid", 30, n);
      chk("t4_reissue_dp_sw", {24'd0, dp_sw}, 32'h76);
      tick();
      wait_idle("t4_idle", 20, n);

      // 5: reset while dp_valid=1 drops the issue, then 0xE3 is reissued
      sw = 8'hE3; dp_led = 2'b10; dp_ready = 1'b0;
      wait_valid("t5_valid", 20, n);
      rst = 1'b1;
      tick();
      chk("t5_rst_valid", {31'd0, dp_valid}, 32'd0);
      chk("t5_rst_leds", {30'd0, Led2, Led1}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      dp_ready = 1'b1;
      exp_q.push_back('{sw: 8'hE3, led: 2'b10});
      wait_valid("t5_reissue_valid", 20, n);
      chk("t5_reissue_latency", n, DEB + 2);
      tick();
      wait_idle("t5_idle", 20, n);
      tick(); tick();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("handshake_count", hs_count, 32'd4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
